// File: rtl/vga_sync.sv
// VGA timing generator: free-running pixel/line counters with combinational sync and active-video decodes.
// Latency: decodes align with x_px/y_px in the same cycle; no backpressure, the counters never stall.
module vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 128,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 9,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 28,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0
) (
    input  logic       px_clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       activevideo
);

    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_x_wrap;
    logic       w_y_wrap;
    logic       w_hs_on;
    logic       w_vs_on;

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);

    // The line counter only moves on the pixel-counter wrap, so vsync changes at x=0.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_wrap) begin
            r_x <= '0;
            r_y <= w_y_wrap ? '0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    assign w_hs_on = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
    assign w_vs_on = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

    assign hsync       = w_hs_on ? H_POL : ~H_POL;
    assign vsync       = w_vs_on ? V_POL : ~V_POL;
    assign activevideo = (r_x < H_ACT_END) && (r_y < V_ACT_END);
    assign x_px        = r_x;
    assign y_px        = r_y;

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboarded bench: dut_a uses the 640x480@72 timing, dut_b a shrunken frame with active-high syncs.
module tb_vga_sync;

    logic       px_clk = 1'b0;
    logic       reset_a, reset_b;
    logic       hs_a, vs_a, av_a, hs_b, vs_b, av_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    always #5 px_clk = ~px_clk;

    vga_sync dut_a (
        .px_clk(px_clk), .reset(reset_a), .hsync(hs_a), .vsync(vs_a),
        .x_px(x_a), .y_px(y_a), .activevideo(av_a)
    );

    // 25 pixels x 13 lines: hsync on x 18..20, vsync on y 8..9, frame = 325 clocks.
    vga_sync #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
        .V_ACTIVE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .H_POL(1'b1),  .V_POL(1'b1)
    ) dut_b (
        .px_clk(px_clk), .reset(reset_b), .hsync(hs_b), .vsync(vs_b),
        .x_px(x_b), .y_px(y_b), .activevideo(av_b)
    );

    typedef struct packed {
        logic       sel;
        logic [9:0] x;
        logic [9:0] y;
        logic       av;
        logic       hs;
        logic       vs;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    vs_rise_t[$];
    logic  vs_b_prev = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge px_clk);
        #1;
    endtask

    task automatic expect_out(input logic sel, input int x, input int y,
                              input logic av, input logic hs, input logic vs, input string nm);
        exp_t e;
        e.sel = sel; e.x = 10'(x); e.y = 10'(y); e.av = av; e.hs = hs; e.vs = vs;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every output sample is compared against the oldest pending expectation.
    always @(negedge px_clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        cyc++;
        if (vs_b && !vs_b_prev && !reset_b) vs_rise_t.push_back(cyc);
        vs_b_prev = vs_b;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.sel = e.sel;
            if (e.sel) begin
                a.x = x_b; a.y = y_b; a.av = av_b; a.hs = hs_b; a.vs = vs_b;
            end else begin
                a.x = x_a; a.y = y_a; a.av = av_a; a.hs = hs_a; a.vs = vs_a;
            end
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got x=%0d y=%0d av=%b hs=%b vs=%b, expected x=%0d y=%0d av=%b hs=%b vs=%b",
                         nm, a.x, a.y, a.av, a.hs, a.vs, e.x, e.y, e.av, e.hs, e.vs);
            end
        end
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;

        // Full-size timing on dut_a.
        tick(2);
        reset_a = 1'b0;
        tick(137); expect_out(0, 137, 0, 1, 1, 1, "a_free_run");
        reset_a = 1'b1;
        tick(3);   expect_out(0, 0, 0, 1, 1, 1, "a_reset_hold");
        reset_a = 1'b0;
        tick(1);   expect_out(0, 1, 0, 1, 1, 1, "a_first_count");
        tick(638); expect_out(0, 639, 0, 1, 1, 1, "a_last_active");
        tick(1);   expect_out(0, 640, 0, 0, 1, 1, "a_front_porch");
        tick(23);  expect_out(0, 663, 0, 0, 1, 1, "a_pre_hsync");
        tick(1);   expect_out(0, 664, 0, 0, 0, 1, "a_hsync_start");
        tick(39);  expect_out(0, 703, 0, 0, 0, 1, "a_hsync_end");
        tick(1);   expect_out(0, 704, 0, 0, 1, 1, "a_back_porch");
        tick(127); expect_out(0, 831, 0, 0, 1, 1, "a_line_end");
        tick(1);   expect_out(0, 0, 1, 1, 1, 1, "a_line_wrap");
        tick(500); expect_out(0, 500, 1, 1, 1, 1, "a_mid_line");
        reset_a = 1'b1;
        tick(1);   expect_out(0, 0, 0, 1, 1, 1, "a_mid_line_reset");
        reset_a = 1'b0;
        tick(1);   expect_out(0, 1, 0, 1, 1, 1, "a_resume");

        // Shrunken frame with active-high syncs on dut_b.
        reset_b = 1'b0;
        expect_out(1, 0, 0, 1, 0, 0, "b_reset_state");
        tick(15);  expect_out(1, 15, 0, 1, 0, 0, "b_last_active");
        tick(1);   expect_out(1, 16, 0, 0, 0, 0, "b_front_porch");
        tick(2);   expect_out(1, 18, 0, 0, 1, 0, "b_hsync_start");
        tick(2);   expect_out(1, 20, 0, 0, 1, 0, "b_hsync_end");
        tick(1);   expect_out(1, 21, 0, 0, 0, 0, "b_back_porch");
        tick(3);   expect_out(1, 24, 0, 0, 0, 0, "b_line_end");
        tick(1);   expect_out(1, 0, 1, 1, 0, 0, "b_line_wrap");
        tick(125); expect_out(1, 0, 6, 0, 0, 0, "b_vblank_line");
        tick(49);  expect_out(1, 24, 7, 0, 0, 0, "b_pre_vsync");
        tick(1);   expect_out(1, 0, 8, 0, 0, 1, "b_vsync_start");
        tick(49);  expect_out(1, 24, 9, 0, 0, 1, "b_vsync_end");
        tick(1);   expect_out(1, 0, 10, 0, 0, 0, "b_vsync_off");
        tick(74);  expect_out(1, 24, 12, 0, 0, 0, "b_frame_end");
        tick(1);   expect_out(1, 0, 0, 1, 0, 0, "b_frame_wrap");
        tick(200); expect_out(1, 0, 8, 0, 0, 1, "b_vsync_frame2");
        tick(1);
        check_int("b_vsync_rise_count", vs_rise_t.size(), 2);
        if (vs_rise_t.size() >= 2)
            check_int("b_frame_period", vs_rise_t[1] - vs_rise_t[0], 325);
        tick(234); expect_out(1, 10, 4, 1, 0, 0, "b_mid_frame");
        reset_b = 1'b1;
        tick(1);   expect_out(1, 0, 0, 1, 0, 0, "b_mid_frame_reset");
        reset_b = 1'b0;
        tick(200); expect_out(1, 0, 8, 0, 0, 1, "b_vsync_after_reset");
        tick(1);
        check_int("b_vsync_rise_after_reset", vs_rise_t.size(), 3);
        if (vs_rise_t.size() >= 3)
            check_int("b_reset_to_vsync", vs_rise_t[2] - vs_rise_t[1], 436);

        tick(2);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
